// File: rtl/de_selector14_driver.sv
// -----------------------------------------------------------------------------
// de_selector14_driver
//
// Purpose:
//   Serialises a 4-bit parallel word onto a downstream 1-to-4 demux. Each bit
//   k of the accepted word is presented on oC while {oS1,oS0}=k, and each
//   channel is held for HOLD_CYCLES clock cycles. A frame therefore lasts
//   4*HOLD_CYCLES cycles. It is followed by a single DONE cycle in which
//   oDone pulses.
//
// Parameters:
//   HOLD_CYCLES : cycles each channel is presented (legal range 1..255)
//
// Ports:
//   iClk    in   clock; all state changes on its rising edge
//   iRst_n  in   asynchronous active-low reset
//   iData   in   [3:0] parallel word; bit k goes to demux output k
//   iValid  in   iData is valid
//   oReady  out  block accepts a word this cycle (transfer = iValid & oReady)
//   oC      out  serial data to the demux data input
//   oS1     out  demux select MSB
//   oS0     out  demux select LSB
//   oBusy   out  a frame is in progress
//   oDone   out  one-cycle pulse at the end of a frame
//
// Configuration macro:
//   DE_SELECTOR14_DRIVER_B2B_EN : when defined, oReady is also asserted in
//   DONE. A word accepted there starts the next frame immediately, so frames
//   are separated by exactly one DONE cycle.
//
// All outputs are registered. They are computed from the next-state values,
// so the cycle right after a transfer edge already shows channel 0 of the new
// word.
// -----------------------------------------------------------------------------
module de_selector14_driver #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [3:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic       oC,
  output logic       oS1,
  output logic       oS0,
  output logic       oBusy,
  output logic       oDone
);

  localparam logic [7:0] LP_CNT_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [1:0] LP_CH_LAST  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // State
  state_t     r_state;
  logic [1:0] r_ch;
  logic [7:0] r_cnt;
  logic [3:0] r_shadow;

  // Registered outputs
  logic       r_ready;
  logic       r_c;
  logic [1:0] r_sel;
  logic       r_busy;
  logic       r_done;

  // Next-state values
  state_t     w_state_nxt;
  logic [1:0] w_ch_nxt;
  logic [7:0] w_cnt_nxt;
  logic [3:0] w_shadow_nxt;
  logic       w_take;

  // Next output values
  logic       w_ready_nxt;
  logic       w_c_nxt;
  logic [1:0] w_sel_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;

  // r_ready mirrors the states that accept a word. It is also low during the
  // first cycle after reset release, so no transfer can occur on that edge.
  assign w_take = iValid & r_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_ch_nxt     = r_ch;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;

    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_state_nxt  = ST_SEND;
          w_ch_nxt     = 2'd0;
          w_cnt_nxt    = 8'd0;
          w_shadow_nxt = iData;
        end
      end

      ST_SEND: begin
        if (r_cnt == LP_CNT_LAST) begin
          w_cnt_nxt = 8'd0;
          if (r_ch == LP_CH_LAST) begin
            // The last channel has had its full hold time; end the frame
            // rather than wrapping back to channel 0.
            w_state_nxt = ST_DONE;
            w_ch_nxt    = 2'd0;
          end else begin
            w_ch_nxt = r_ch + 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      ST_DONE: begin
`ifdef DE_SELECTOR14_DRIVER_B2B_EN
        if (w_take) begin
          w_state_nxt  = ST_SEND;
          w_ch_nxt     = 2'd0;
          w_cnt_nxt    = 8'd0;
          w_shadow_nxt = iData;
        end else begin
          w_state_nxt = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_ch_nxt    = 2'd0;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Output decode from the next state, so each output register holds the value
  // that belongs to the state being entered.
  always_comb begin
    w_ready_nxt = 1'b0;
    w_c_nxt     = 1'b0;
    w_sel_nxt   = 2'd0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (w_state_nxt)
      ST_IDLE: begin
        w_ready_nxt = 1'b1;
      end

      ST_SEND: begin
        w_busy_nxt = 1'b1;
        w_sel_nxt  = w_ch_nxt;
        w_c_nxt    = w_shadow_nxt[w_ch_nxt];
      end

      ST_DONE: begin
        w_done_nxt = 1'b1;
`ifdef DE_SELECTOR14_DRIVER_B2B_EN
        w_ready_nxt = 1'b1;
`endif
      end

      default: begin
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state  <= ST_IDLE;
      r_ch     <= 2'd0;
      r_cnt    <= 8'd0;
      r_shadow <= 4'd0;
      r_ready  <= 1'b0;
      r_c      <= 1'b0;
      r_sel    <= 2'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ch     <= w_ch_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_ready  <= w_ready_nxt;
      r_c      <= w_c_nxt;
      r_sel    <= w_sel_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign oReady = r_ready;
  assign oC     = r_c;
  assign oS1    = r_sel[1];
  assign oS0    = r_sel[0];
  assign oBusy  = r_busy;
  assign oDone  = r_done;

endmodule

// File: tb/tb_de_selector14_driver.sv
// -----------------------------------------------------------------------------
// Bench for de_selector14_driver. Two instances share clock and reset:
// dut_a uses HOLD_CYCLES=4 and dut_b uses HOLD_CYCLES=1. The expected value of
// every output is derived from the cycle index k since the transfer edge:
//   channel = (k-1)/H, data = word[channel].
// DONE falls at k = 4H+1.
// -----------------------------------------------------------------------------
module tb_de_selector14_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, a_c, a_s1, a_s0, a_busy, a_done;
  logic       b_ready, b_c, b_s1, b_s0, b_busy, b_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  de_selector14_driver #(.HOLD_CYCLES(4)) dut_a (
    .iClk(clk), .iRst_n(rst_n), .iData(a_data), .iValid(a_valid),
    .oReady(a_ready), .oC(a_c), .oS1(a_s1), .oS0(a_s0),
    .oBusy(a_busy), .oDone(a_done)
  );

  de_selector14_driver #(.HOLD_CYCLES(1)) dut_b (
    .iClk(clk), .iRst_n(rst_n), .iData(b_data), .iValid(b_valid),
    .oReady(b_ready), .oC(b_c), .oS1(b_s1), .oS0(b_s0),
    .oBusy(b_busy), .oDone(b_done)
  );

`ifdef DE_SELECTOR14_DRIVER_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  // Observed vector: {ready, busy, done, s1, s0, c}
  function automatic logic [5:0] obs(input bit sel);
    if (sel) return {b_ready, b_busy, b_done, b_s1, b_s0, b_c};
    else     return {a_ready, a_busy, a_done, a_s1, a_s0, a_c};
  endfunction

  function automatic logic [5:0] vec(input logic rdy, input logic bsy,
                                     input logic dn, input int ch,
                                     input logic c);
    logic [1:0] s;
    s = ch[1:0];
    return {rdy, bsy, dn, s, c};
  endfunction

  task automatic chk(input string tag, input logic [5:0] o, input logic [5:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed={rdy,bsy,dn,s1,s0,c}=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [3:0] d);
    if (sel) begin b_valid = v; b_data = d; end
    else     begin a_valid = v; a_data = d; end
  endtask

  task automatic set_data(input bit sel, input logic [3:0] d);
    if (sel) b_data = d; else a_data = d;
  endtask

  task automatic clear_valid(input bit sel);
    if (sel) b_valid = 1'b0; else a_valid = 1'b0;
  endtask

  // Called just after a negedge with the DUT idle: offer the word and step to
  // the negedge after the transfer edge.
  task automatic start(input bit sel, input logic [3:0] word, input string tag);
    chk({tag, "_idle_ready"}, obs(sel), vec(1'b1, 1'b0, 1'b0, 0, 1'b0));
    drive(sel, 1'b1, word);
    @(negedge clk);
  endtask

  // Checks the 4H SEND cycles and the DONE cycle, and returns at the DONE
  // negedge. mode: 0 leaves iData alone, 1 zeroes it, 2 randomises it.
  task automatic body(input bit sel, input int h, input logic [3:0] word,
                      input int mode, input bit keep, input string tag);
    int ch;
    for (int k = 1; k <= 4 * h; k++) begin
      if (k == 1 && !keep) clear_valid(sel);
      if (mode == 1) set_data(sel, 4'b0000);
      if (mode == 2) set_data(sel, 4'($urandom));
      ch = (k - 1) / h;
      chk($sformatf("%s_send_k%0d", tag, k), obs(sel),
          vec(1'b0, 1'b1, 1'b0, ch, word[ch]));
      @(negedge clk);
    end
    chk({tag, "_done"}, obs(sel), vec(B2B, 1'b0, 1'b1, 0, 1'b0));
  endtask

  task automatic idle_chk(input bit sel, input string tag);
    chk(tag, obs(sel), vec(1'b1, 1'b0, 1'b0, 0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] w;
    bit         sel;
    int         mode;
    int         gap;

    rst_n   = 1'b0;
    a_valid = 1'b0; a_data = 4'd0;
    b_valid = 1'b0; b_data = 4'd0;

    // Reset state before any clock edge
    #2;
    chk("rst_a", obs(1'b0), 6'b000000);
    chk("rst_b", obs(1'b1), 6'b000000);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_a_not_ready", obs(1'b0), 6'b000000);
    @(negedge clk);
    idle_chk(1'b0, "rel_a_ready");
    idle_chk(1'b1, "rel_b_ready");

    // H=4, word 1010
    start(1'b0, 4'b1010, "f1010");
    body(1'b0, 4, 4'b1010, 0, 1'b0, "f1010");
    @(negedge clk);
    idle_chk(1'b0, "f1010_after");

    // Word latched at the transfer; later iData changes are ignored
    start(1'b0, 4'b0110, "f0110");
    body(1'b0, 4, 4'b0110, 1, 1'b0, "f0110");
    @(negedge clk);
    idle_chk(1'b0, "f0110_after");

    // H=1, word 0001: channel changes every cycle, DONE at cycle 5
    start(1'b1, 4'b0001, "h1");
    body(1'b1, 1, 4'b0001, 0, 1'b0, "h1");
    @(negedge clk);
    idle_chk(1'b1, "h1_after");

    if (!B2B) begin
      // iValid held with 1111: one frame, an IDLE cycle, then the next frame
      start(1'b0, 4'b1111, "hold1");
      body(1'b0, 4, 4'b1111, 0, 1'b1, "hold1");
      @(negedge clk);
      start(1'b0, 4'b1111, "hold2");
      body(1'b0, 4, 4'b1111, 0, 1'b0, "hold2");
      @(negedge clk);
      idle_chk(1'b0, "hold2_after");
    end else begin
      // Back-to-back: second frame's channel 0 follows DONE directly
      start(1'b0, 4'b0101, "b2b1");
      body(1'b0, 4, 4'b0101, 0, 1'b1, "b2b1");
      a_data = 4'b1100;
      @(negedge clk);
      body(1'b0, 4, 4'b1100, 0, 1'b0, "b2b2");
      @(negedge clk);
      idle_chk(1'b0, "b2b2_after");
    end

    // Randomised frames on both instances
    for (int i = 0; i < 16; i++) begin
      w    = 4'($urandom);
      sel  = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      gap  = $urandom_range(0, 3);
      start(sel, w, $sformatf("rnd%0d", i));
      body(sel, sel ? 1 : 4, w, mode, 1'b0, $sformatf("rnd%0d", i));
      @(negedge clk);
      for (int g = 0; g <= gap; g++) begin
        idle_chk(sel, $sformatf("rnd%0d_gap%0d", i, g));
        if (g < gap) @(negedge clk);
      end
    end

    // Asynchronous reset at channel 2 of an H=4 frame
    start(1'b0, 4'b1011, "rstf");
    for (int k = 1; k <= 9; k++) begin
      if (k == 1) a_valid = 1'b0;
      chk($sformatf("rstf_send_k%0d", k), obs(1'b0),
          vec(1'b0, 1'b1, 1'b0, (k - 1) / 4, w_bit(4'b1011, (k - 1) / 4)));
      if (k < 9) @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstf_async_a", obs(1'b0), 6'b000000);
    chk("rstf_async_b", obs(1'b1), 6'b000000);
    @(negedge clk);
    chk("rstf_held", obs(1'b0), 6'b000000);
    rst_n = 1'b1;
    #1;
    chk("rstf_rel", obs(1'b0), 6'b000000);
    @(negedge clk);
    idle_chk(1'b0, "rstf_ready");
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      idle_chk(1'b0, $sformatf("rstf_nodone%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic w_bit(input logic [3:0] w, input int i);
    return w[i];
  endfunction

endmodule
